// File: rtl/axis_pattern_pkg.sv
// Shared definitions for the AXI4-Stream test-pattern source: mode encodings,
// FSM state type and the default Galois LFSR feedback taps.
package axis_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_UP    = 2'b00,
        MODE_DOWN  = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_CONST = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/axis_pattern_next.sv
// Combinational next-value generator: advances the pattern data by one beat
// according to the selected mode (up, down, Galois LFSR, constant).
module axis_pattern_next
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] poly,
    output logic [DATA_WIDTH-1:0] next_data
);

    always_comb begin
        next_data = data;
        case (mode)
            MODE_UP:   next_data = data + step;
            MODE_DOWN: next_data = data - step;
            // Right-shifting Galois form: feedback taps applied when the bit shifted out is 1
            MODE_LFSR: next_data = (data >> 1) ^ (data[0] ? poly : '0);
            default:   next_data = data;
        endcase
    end

endmodule

// File: rtl/axis_pattern_streamer.sv
// AXI4-Stream pattern source: emits packets of configurable pattern data with
// programmable length, packet count and inter-packet gap, honouring back-pressure.
module axis_pattern_streamer
    import axis_pattern_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          LEN_WIDTH  = 16,
    parameter int          GAP_WIDTH  = 8,
    parameter logic [31:0] LFSR_POLY  = DEFAULT_LFSR_POLY
) (
    input  logic                  counter_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [DATA_WIDTH-1:0] cfg_step,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]  cfg_num_pkts,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  pkt_count
);

    localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(LFSR_POLY);

    state_t                state, next_state;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] step_q, data_q, data_adv;
    logic [LEN_WIDTH-1:0]  len_q, num_q, beat_cnt, next_beat, len_sel, pkt_count_q;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt;
    logic                  stop_seen, stop_any, xfer, run_end;
    logic                  tvalid_q, tlast_q, busy_q, done_q;

    axis_pattern_next #(.DATA_WIDTH(DATA_WIDTH)) u_next (
        .mode      (mode_q),
        .data      (data_q),
        .step      (step_q),
        .poly      (POLY),
        .next_data (data_adv)
    );

    assign xfer     = (state == SEND) && m_axis_tready;
    assign stop_any = stop_seen | stop;
    assign run_end  = stop_any || ((num_q != '0) && (pkt_count_q + LEN_WIDTH'(1) == num_q));
    // In IDLE the length being loaded comes straight from the config port
    assign len_sel  = (state == IDLE) ? ((cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len) : len_q;

    always_comb begin
        next_state = state;
        next_beat  = beat_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SEND;
                    next_beat  = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (tlast_q) begin
                        next_beat = '0;
                        if (run_end)
                            next_state = IDLE;
                        else if (gap_q != '0)
                            next_state = GAP;
                    end else begin
                        next_beat = beat_cnt + LEN_WIDTH'(1);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == gap_q - GAP_WIDTH'(1))
                    next_state = stop_any ? IDLE : SEND;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge counter_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= '0;
            step_q      <= '0;
            data_q      <= '0;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            beat_cnt    <= '0;
            pkt_count_q <= '0;
            stop_seen   <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state    <= next_state;
            beat_cnt <= next_beat;
            tvalid_q <= (next_state == SEND);
            busy_q   <= (next_state != IDLE);
            tlast_q  <= (next_state == SEND) && (next_beat == len_sel - LEN_WIDTH'(1));
            done_q   <= (state != IDLE) && (next_state == IDLE);
            case (state)
                IDLE: begin
                    stop_seen <= 1'b0;
                    if (start) begin
                        mode_q      <= cfg_mode;
                        step_q      <= cfg_step;
                        len_q       <= len_sel;
                        num_q       <= cfg_num_pkts;
                        gap_q       <= cfg_gap;
                        gap_cnt     <= '0;
                        pkt_count_q <= '0;
                        data_q      <= ((cfg_mode == MODE_LFSR) && (cfg_seed == '0))
                                       ? DATA_WIDTH'(1) : cfg_seed;
                    end
                end
                SEND: begin
                    if (stop) stop_seen <= 1'b1;
                    if (xfer) data_q <= data_adv;
                    if (xfer && tlast_q) pkt_count_q <= pkt_count_q + LEN_WIDTH'(1);
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (stop) stop_seen <= 1'b1;
                    gap_cnt <= gap_cnt + GAP_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = pkt_count_q;

endmodule
